// File: rtl/div_sequencer.sv
// Control stage for the 4-bit restoring divider: launches a Go/operand handshake on a Start edge,
// captures the result, screens divide-by-zero, detects divider timeouts and counts completed operations.
module div_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic [3:0]       i_Dividend,
    input  logic [3:0]       i_Divisor,
    output logic             o_DivGo,
    output logic [3:0]       o_DivDividend,
    output logic [3:0]       o_DivDivisor,
    input  logic             i_DivValid,
    input  logic [3:0]       i_DivQuotient,
    input  logic [3:0]       i_DivRemainder,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [3:0]       o_QuotOut,
    output logic [3:0]       o_RemOut,
    output logic             o_DivByZero,
    output logic             o_Error,
    output logic [CNT_W-1:0] o_OpCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_HOLD
    } state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic       r_start_d;
    logic [7:0] r_tcnt;
    logic       w_start_rise;

    assign w_start_rise = i_Start & ~r_start_d;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state       <= S_IDLE;
            r_start_d     <= 1'b0;
            r_tcnt        <= '0;
            o_DivGo       <= 1'b0;
            o_DivDividend <= '0;
            o_DivDivisor  <= '0;
            o_Busy        <= 1'b0;
            o_Done        <= 1'b0;
            o_QuotOut     <= '0;
            o_RemOut      <= '0;
            o_DivByZero   <= 1'b0;
            o_Error       <= 1'b0;
            o_OpCount     <= '0;
        end else begin
            // Edge history is tracked in every state so edges seen while busy are consumed, not queued.
            r_start_d <= i_Start;
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_start_rise) begin
                        o_Error <= 1'b0;
                        if (i_Divisor == '0) begin
                            r_state     <= S_HOLD;
                            o_Done      <= 1'b1;
                            o_QuotOut   <= '1;
                            o_RemOut    <= i_Dividend;
                            o_DivByZero <= 1'b1;
                            o_OpCount   <= o_OpCount + CNT_W'(1);
                        end else begin
                            r_state       <= S_REQ;
                            r_tcnt        <= '0;
                            o_DivDividend <= i_Dividend;
                            o_DivDivisor  <= i_Divisor;
                            o_DivGo       <= 1'b1;
                            o_Busy        <= 1'b1;
                            o_Done        <= 1'b0;
                            o_DivByZero   <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (i_DivValid) begin
                        r_state   <= S_RELEASE;
                        r_tcnt    <= '0;
                        o_DivGo   <= 1'b0;
                        o_QuotOut <= i_DivQuotient;
                        o_RemOut  <= i_DivRemainder;
                        o_OpCount <= o_OpCount + CNT_W'(1);
                    end else if (r_tcnt == TLAST) begin
                        r_state   <= S_RELEASE;
                        r_tcnt    <= '0;
                        o_DivGo   <= 1'b0;
                        o_Error   <= 1'b1;
                        o_QuotOut <= '0;
                        o_RemOut  <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (!i_DivValid) begin
                        r_state <= S_HOLD;
                        o_Busy  <= 1'b0;
                        o_Done  <= 1'b1;
                    end else if (r_tcnt == TLAST) begin
                        r_state <= S_HOLD;
                        o_Busy  <= 1'b0;
                        o_Done  <= 1'b1;
                        o_Error <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural divider plus a per-operation result model checked every
// cycle Done or DivGo is high, and directed operations with literal expectations.
module tb_div_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dd;
    logic [3:0] dv;
    logic       o_DivGo;
    logic [3:0] o_DivDividend;
    logic [3:0] o_DivDivisor;
    logic       d_valid;
    logic [3:0] d_q;
    logic [3:0] d_r;
    logic       o_Busy;
    logic       o_Done;
    logic [3:0] o_QuotOut;
    logic [3:0] o_RemOut;
    logic       o_DivByZero;
    logic       o_Error;
    logic [7:0] o_OpCount;

    int n_vec = 0;
    int n_err = 0;

    // Expected result of the most recently launched operation
    logic [3:0] m_q, m_r, m_dd, m_dv;
    bit         m_dbz, m_err;
    logic [7:0] m_cnt;

    // Divider stand-in
    int         d_st;
    int         d_cnt;
    logic [3:0] d_a, d_b;
    bit         hang;

    always #5 clk = ~clk;

    div_sequencer #(.TIMEOUT_CYCLES(15), .CNT_W(8)) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Start       (start),
        .i_Dividend    (dd),
        .i_Divisor     (dv),
        .o_DivGo       (o_DivGo),
        .o_DivDividend (o_DivDividend),
        .o_DivDivisor  (o_DivDivisor),
        .i_DivValid    (d_valid),
        .i_DivQuotient (d_q),
        .i_DivRemainder(d_r),
        .o_Busy        (o_Busy),
        .o_Done        (o_Done),
        .o_QuotOut     (o_QuotOut),
        .o_RemOut      (o_RemOut),
        .o_DivByZero   (o_DivByZero),
        .o_Error       (o_Error),
        .o_OpCount     (o_OpCount)
    );

    // Go sampled, one load cycle, four iterations, then ResultValid until Go is seen low.
    always @(posedge clk) begin
        if (rst) begin
            d_st    <= 0;
            d_cnt   <= 0;
            d_valid <= 1'b0;
        end else begin
            case (d_st)
                0: if (o_DivGo) begin
                    d_a   <= o_DivDividend;
                    d_b   <= o_DivDivisor;
                    d_cnt <= 0;
                    d_st  <= 1;
                end
                1: if (!o_DivGo) d_st <= 0;
                   else if (d_cnt == 4) begin
                       if (!hang) begin
                           d_valid <= 1'b1;
                           d_st    <= 2;
                       end
                   end else d_cnt <= d_cnt + 1;
                default: if (!o_DivGo) begin
                    d_valid <= 1'b0;
                    d_st    <= 0;
                end
            endcase
        end
    end

    assign d_q = d_valid ? d_a / d_b : 4'hA;
    assign d_r = d_valid ? d_a % d_b : 4'h5;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_Done) begin
                check("hold_quot", o_QuotOut, m_q);
                check("hold_rem", o_RemOut, m_r);
                check("hold_dbz", o_DivByZero, m_dbz);
                check("hold_err", o_Error, m_err);
                check("hold_cnt", o_OpCount, m_cnt);
                check("hold_busy", o_Busy, 0);
                check("hold_go", o_DivGo, 0);
            end
            if (o_DivGo) begin
                check("go_dividend", o_DivDividend, m_dd);
                check("go_divisor", o_DivDivisor, m_dv);
                check("go_busy", o_Busy, 1);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge following Done (unless keep).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit poke, input bit keep);
        int go_n;
        int lat;
        dd    = a;
        dv    = b;
        start = 1'b1;
        @(posedge clk); #1;
        if (b == 4'd0) begin
            m_q = 4'hF; m_r = a; m_dbz = 1'b1; m_err = 1'b0; m_cnt = m_cnt + 8'd1;
        end else begin
            m_dd = a; m_dv = b; m_dbz = 1'b0;
            if (hang) begin
                m_q = 4'd0; m_r = 4'd0; m_err = 1'b1;
            end else begin
                m_q = a / b; m_r = a % b; m_err = 1'b0; m_cnt = m_cnt + 8'd1;
            end
        end
        check("launch_go", o_DivGo, int'(b != 4'd0));
        check("launch_busy", o_Busy, int'(b != 4'd0));
        if (!keep) start = 1'b0;
        go_n = 0;
        lat  = 0;
        while (!o_Done && lat < 40) begin
            if (o_DivGo) go_n++;
            if (poke && lat == 1) begin dd = 4'd2; start = 1'b1; end
            if (poke && lat == 3) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("go_cycles", go_n, (b == 4'd0) ? 0 : (hang ? 15 : 7));
        check("done_latency", lat, (b == 4'd0) ? 0 : (hang ? 16 : 9));
        if (!keep) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; dd = 4'd0; dv = 4'd0; hang = 1'b0;
        m_q = 4'd0; m_r = 4'd0; m_dd = 4'd0; m_dv = 4'd0; m_dbz = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_go", o_DivGo, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_done", o_Done, 0);
        check("rst_quot", o_QuotOut, 0);
        check("rst_dbz", o_DivByZero, 0);
        check("rst_cnt", o_OpCount, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(4'd13, 4'd4, 1'b0, 1'b0);
        check("lit_13_4_q", o_QuotOut, 3);
        check("lit_13_4_r", o_RemOut, 1);
        check("lit_13_4_cnt", o_OpCount, 1);
        check("lit_13_4_err", o_Error, 0);

        run_op(4'd15, 4'd0, 1'b0, 1'b0);
        check("lit_dbz_q", o_QuotOut, 15);
        check("lit_dbz_r", o_RemOut, 15);
        check("lit_dbz_flag", o_DivByZero, 1);
        check("lit_dbz_cnt", o_OpCount, 2);

        run_op(4'd9, 4'd2, 1'b1, 1'b0);
        check("lit_poke_dd", o_DivDividend, 9);
        check("lit_poke_q", o_QuotOut, 4);
        check("lit_poke_r", o_RemOut, 1);
        check("lit_poke_cnt", o_OpCount, 3);

        hang = 1'b1;
        run_op(4'd6, 4'd3, 1'b0, 1'b0);
        hang = 1'b0;
        check("lit_tmo_err", o_Error, 1);
        check("lit_tmo_q", o_QuotOut, 0);
        check("lit_tmo_r", o_RemOut, 0);
        check("lit_tmo_cnt", o_OpCount, 3);

        run_op(4'd8, 4'd0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("held_start_cnt", o_OpCount, 4);
        start = 1'b0;
        @(posedge clk); #1;

        dd = 4'd5; dv = 4'd3; m_dd = 4'd5; m_dv = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_go", o_DivGo, 0);
        check("midrst_busy", o_Busy, 0);
        check("midrst_done", o_Done, 0);
        check("midrst_cnt", o_OpCount, 0);
        rst = 1'b0;
        m_cnt = 8'd0;
        @(posedge clk); #1;
        run_op(4'd7, 4'd7, 1'b0, 1'b0);
        check("lit_7_7_q", o_QuotOut, 1);
        check("lit_7_7_r", o_RemOut, 0);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 8'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            run_op(4'(i * 5 + 1), 4'(i * 3), 1'b0, 1'b0);
        end
        check("wrap_cnt", o_OpCount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Upstream control stage for the 4-bit restoring divider.
- Accepts a user request (operands plus Start), then drives the divider's Go/Dividend/Divisor handshake and waits for ResultValid.
- Captures Quotient and Remainder, drops Go, and waits for the divider to return to idle.
- Holds the result for display, screens out divide-by-zero without issuing Go, flags a divider timeout, and counts completed operations.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles in REQ waiting for ResultValid before Error; legal range 8..255.
- CNT_W, 8: width of the completed-operation counter OpCount.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request level from a key/switch; only its rising edge (0 in previous cycle, 1 now) launches an operation.
- Dividend  in  4  user dividend, unsigned.
- Divisor  in  4  user divisor, unsigned.
- DivGo  out  1  Go to the divider; registered.
- DivDividend  out  4  dividend to the divider; registered, stable while DivGo=1.
- DivDivisor  out  4  divisor to the divider; registered, stable while DivGo=1.
- DivValid  in  1  ResultValid from the divider.
- DivQuotient  in  4  divider quotient; valid only while DivValid=1.
- DivRemainder  in  4  divider remainder; valid only while DivValid=1.
- Busy  out  1  high in REQ and RELEASE.
- Done  out  1  high in HOLD; result outputs valid.
- QuotOut  out  4  captured quotient.
- RemOut  out  4  captured remainder.
- DivByZero  out  1  last request had Divisor=0.
- Error  out  1  last request timed out.
- OpCount  out  CNT_W  completed operations (normal + div-by-zero); wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-operation):
  - State=IDLE.
  - All outputs 0; OpCount=0; Start edge-detect register=0; timeout counter=0.
  - DivGo drops to 0 on the edge where Reset is sampled.
- States: IDLE, REQ, RELEASE, HOLD. All outputs are registered; no combinational path from inputs to outputs.
- IDLE / HOLD on Start rising edge:
  - Divisor==0:
    - No Go; go to HOLD.
    - QuotOut=4'hF, RemOut=Dividend, DivByZero=1, Error=0, OpCount+1.
  - Otherwise:
    - Latch Dividend/Divisor into DivDividend/DivDivisor; DivGo=1; go to REQ.
    - Clear DivByZero and Error; clear timeout counter.
- REQ:
  - DivGo held 1; timeout counter increments each cycle.
  - On DivValid=1 (priority over timeout):
    - Capture QuotOut=DivQuotient, RemOut=DivRemainder; OpCount+1.
    - DivGo=0; go to RELEASE.
  - Else if the counter reaches TIMEOUT_CYCLES-1:
    - Error=1, QuotOut=RemOut=0, OpCount unchanged.
    - DivGo=0; go to RELEASE.
- RELEASE:
  - DivGo=0; wait until DivValid=0, then go to HOLD.
  - If DivValid is still 1 after TIMEOUT_CYCLES cycles, set Error=1 and go to HOLD.
- HOLD:
  - Done=1; results held indefinitely.
  - A new Start rising edge behaves as in IDLE (results and flags overwritten on that edge).
- Start edges in REQ/RELEASE are ignored and not queued. A Start held high launches exactly one operation.
- Operand changes while Busy have no effect on DivDividend/DivDivisor.
- Latency with the team divider (Go sampled, 1 load cycle, 4 iterations):
  - Start rising edge sampled at edge k → DivGo=1 after edge k.
  - DivValid high after edge k+6; capture at edge k+7.
  - DivValid low one cycle after DivGo falls; Done=1 after edge k+9.

Test Plan:
- Reset, then Dividend=13, Divisor=4, pulse Start → DivGo high for exactly the REQ cycles; Done=1, QuotOut=3, RemOut=1, OpCount=1, DivByZero=0, Error=0.
- Dividend=15, Divisor=0, Start → DivGo never asserts; Done=1 one cycle after the edge; QuotOut=4'hF, RemOut=15, DivByZero=1, OpCount+1.
- During REQ change Dividend to 2 and toggle Start → DivDividend remains 9 (original 9÷2); result Q=4, R=1; only one operation counted.
- Divider model never asserts DivValid → Error=1 after 15 REQ cycles; DivGo=0; QuotOut=RemOut=0; OpCount unchanged.
- Assert Reset two cycles into REQ → next cycle DivGo=0, Busy=0, Done=0, OpCount=0; a fresh Start (7÷7) yields Q=1, R=0.
- Run 256 back-to-back operations from HOLD (Start toggled each time) → OpCount wraps to 0; each result matches the reference quotient/remainder.
